decode_execute_stage: RTL

- Pipeline register between the register-file read (decode) and the execute stage of the 5-stage RV32I core.
- Captures decoded fields and register-file operands rd1/rd2 and detects load-use hazards, stalling decode for one cycle and inserting a bubble.
- Applies MEM/WB forwarding to its registered operands before they reach the ALU.
- Keeps a saturating stall counter for performance monitoring.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/operand_forward_mux.sv | 32 +++
 rtl/decode_execute_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package pipeline_pkg;

  localparam int CTRL_W = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              reg_we;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_ctrl;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/operand_forward_mux.sv
// Selects an execute operand from the MEM bypass, the WB bypass or the
// registered register-file value; MEM wins over WB and x0 is never bypassed.
module operand_forward_mux
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0]    reg_value,
  input  logic                     mem_we,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic [DATA_WIDTH-1:0]    value
);

  logic idx_nonzero;
  assign idx_nonzero = (idx != ADDRESS_WIDTH'(REG_ZERO));

  always_comb begin
    value = reg_value;
    if (mem_we && (mem_rd == idx) && idx_nonzero) begin
      value = mem_result;
    end else if (wb_we && (wb_rd == idx) && idx_nonzero) begin
      value = wb_result;
    end
  end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with load-use stall, bubble insertion,
// MEM/WB operand forwarding and a saturating stall counter.
module decode_execute_stage
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CTRL_WIDTH    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [DATA_WIDTH-1:0]    pc_i,
  input  logic [ADDRESS_WIDTH-1:0] rs1_i,
  input  logic [ADDRESS_WIDTH-1:0] rs2_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0]    rd1_i,
  input  logic [DATA_WIDTH-1:0]    rd2_i,
  input  logic [DATA_WIDTH-1:0]    imm_i,
  input  logic [CTRL_WIDTH-1:0]    alu_ctrl_i,
  input  logic                     reg_we_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic                     alu_src_i,
  input  logic                     flush_i,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd_i,
  input  logic                     mem_we_i,
  input  logic [DATA_WIDTH-1:0]    mem_result_i,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd_i,
  input  logic                     wb_we_i,
  input  logic [DATA_WIDTH-1:0]    wb_result_i,
  output logic                     stall_o,
  output logic                     valid_o,
  output logic [DATA_WIDTH-1:0]    pc_o,
  output logic [DATA_WIDTH-1:0]    imm_o,
  output logic [DATA_WIDTH-1:0]    op_a_o,
  output logic [DATA_WIDTH-1:0]    op_b_o,
  output logic [ADDRESS_WIDTH-1:0] rd_o,
  output logic [CTRL_WIDTH-1:0]    alu_ctrl_o,
  output logic                     reg_we_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic                     alu_src_o,
  output logic [31:0]              stall_count_o
);

  // valid_i/valid_o qualify an instruction slot; there is no ready. Decode
  // must hold its instruction while stall_o=1, and valid_o=0 marks a bubble.
  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    pc_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic [ADDRESS_WIDTH-1:0] rs1_q;
  logic [ADDRESS_WIDTH-1:0] rs2_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]    rd1_q;
  logic [DATA_WIDTH-1:0]    rd2_q;
  ex_ctrl_t                 ctrl_q;
  ex_ctrl_t                 ctrl_in;
  logic [31:0]              stall_count_q;
  logic                     hazard;

  always_comb begin
    ctrl_in           = BUBBLE_CTRL;
    ctrl_in.reg_we    = reg_we_i;
    ctrl_in.mem_read  = mem_read_i;
    ctrl_in.mem_write = mem_write_i;
    ctrl_in.alu_src   = alu_src_i;
    ctrl_in.alu_ctrl  = CTRL_W'(alu_ctrl_i);
  end

  assign hazard = valid_q && ctrl_q.mem_read && (rd_q != ADDRESS_WIDTH'(REG_ZERO)) &&
                  valid_i && ((rs1_i == rd_q) || (rs2_i == rd_q));
  assign stall_o = hazard && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      ctrl_q        <= BUBBLE_CTRL;
      stall_count_q <= '0;
    end else begin
      if (flush_i || hazard) begin
        valid_q <= 1'b0;
        ctrl_q  <= BUBBLE_CTRL;
      end else begin
        valid_q <= valid_i;
        ctrl_q  <= valid_i ? ctrl_in : BUBBLE_CTRL;
        pc_q    <= pc_i;
        imm_q   <= imm_i;
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
        rd_q    <= rd_i;
        rd1_q   <= rd1_i;
        rd2_q   <= rd2_i;
      end
      if (stall_o && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  operand_forward_mux #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
    .idx        (rs1_q),
    .reg_value  (rd1_q),
    .mem_we     (mem_we_i),
    .mem_rd     (mem_rd_i),
    .mem_result (mem_result_i),
    .wb_we      (wb_we_i),
    .wb_rd      (wb_rd_i),
    .wb_result  (wb_result_i),
    .value      (op_a_o)
  );

  operand_forward_mux #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
    .idx        (rs2_q),
    .reg_value  (rd2_q),
    .mem_we     (mem_we_i),
    .mem_rd     (mem_rd_i),
    .mem_result (mem_result_i),
    .wb_we      (wb_we_i),
    .wb_rd      (wb_rd_i),
    .wb_result  (wb_result_i),
    .value      (op_b_o)
  );

  assign valid_o       = valid_q;
  assign pc_o          = pc_q;
  assign imm_o         = imm_q;
  assign rd_o          = rd_q;
  assign alu_ctrl_o    = CTRL_WIDTH'(ctrl_q.alu_ctrl);
  assign reg_we_o      = ctrl_q.reg_we;
  assign mem_read_o    = ctrl_q.mem_read;
  assign mem_write_o   = ctrl_q.mem_write;
  assign alu_src_o     = ctrl_q.alu_src;
  assign stall_count_o = stall_count_q;

endmodule
